// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions: funct3 access sizes, result-select
// encodings and the MEM/WB bundle layout.
package riscv_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  typedef struct packed {
    logic        reg_write;
    logic [1:0]  result_src;
    logic [31:0] read_data;
    logic [31:0] alu_result;
    logic [31:0] pc_plus4;
    logic [4:0]  rd;
  } memwb_t;

endpackage

// File: rtl/memory_cycle_data_memory.sv
// Word-organised data memory: combinational read, rising-edge write with
// per-byte enables. Contents are never reset.
module data_memory #(
  parameter  int unsigned WORDS = 1024,
  localparam int unsigned AW    = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic [AW-1:0] addr_i,
  input  logic [3:0]    be_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [WORDS];

  // Read sees the pre-edge contents, giving read-before-write on a conflict.
  assign rdata_o = mem_q[addr_i];

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (be_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
    end
  end

endmodule

// File: rtl/memory_cycle.sv
// Memory stage: store lane/byte-enable generation, load extraction and
// extension, and the MEM/WB pipeline register.
module memory_cycle
  import riscv_pkg::*;
#(
  parameter int unsigned DMEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWriteM,
  input  logic        MemWriteM,
  input  logic [1:0]  ResultSrcM,
  input  logic [2:0]  funct3M,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic [31:0] PCPlus4M,
  input  logic [4:0]  RdM,
  output logic        RegWriteW,
  output logic [1:0]  ResultSrcW,
  output logic [31:0] ReadDataW,
  output logic [31:0] ALUResultW,
  output logic [31:0] PCPlus4W,
  output logic [4:0]  RdW
);

  localparam int unsigned AW = $clog2(DMEM_WORDS);

  logic [AW-1:0] word_idx;
  logic [1:0]    lane;
  logic [3:0]    be;
  logic [31:0]   st_data;
  logic [31:0]   rd_word;
  logic [7:0]    rd_byte;
  logic [15:0]   rd_half;
  logic [31:0]   ld_data;
  logic          unused_addr_hi;
  memwb_t        memwb_d, memwb_q;

  // Upper address bits are dropped so accesses wrap modulo the memory size.
  assign word_idx       = ALUResultM[AW+1:2];
  assign lane           = ALUResultM[1:0];
  assign unused_addr_hi = ^ALUResultM[31:AW+2];

  always_comb begin
    st_data = WriteDataM;
    be      = 4'b1111;
    case (funct3M)
      F3_B: begin
        st_data = {4{WriteDataM[7:0]}};
        be      = 4'b0001 << lane;
      end
      F3_H: begin
        st_data = {2{WriteDataM[15:0]}};
        be      = ALUResultM[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        st_data = WriteDataM;
        be      = 4'b1111;
      end
    endcase
    if (!MemWriteM) be = 4'b0000;
  end

  data_memory #(.WORDS(DMEM_WORDS)) u_dmem (
    .clk     (clk),
    .addr_i  (word_idx),
    .be_i    (be),
    .wdata_i (st_data),
    .rdata_o (rd_word)
  );

  assign rd_byte = rd_word[8*lane +: 8];
  assign rd_half = ALUResultM[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    ld_data = rd_word;
    case (funct3M)
      F3_B:    ld_data = {{24{rd_byte[7]}}, rd_byte};
      F3_H:    ld_data = {{16{rd_half[15]}}, rd_half};
      F3_BU:   ld_data = {24'h0, rd_byte};
      F3_HU:   ld_data = {16'h0, rd_half};
      default: ld_data = rd_word;
    endcase
  end

  always_comb begin
    memwb_d.reg_write  = RegWriteM;
    memwb_d.result_src = ResultSrcM;
    memwb_d.read_data  = ld_data;
    memwb_d.alu_result = ALUResultM;
    memwb_d.pc_plus4   = PCPlus4M;
    memwb_d.rd         = RdM;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) memwb_q <= '0;
    else     memwb_q <= memwb_d;
  end

  assign RegWriteW  = memwb_q.reg_write;
  assign ResultSrcW = memwb_q.result_src;
  assign ReadDataW  = memwb_q.read_data;
  assign ALUResultW = memwb_q.alu_result;
  assign PCPlus4W   = memwb_q.pc_plus4;
  assign RdW        = memwb_q.rd;

endmodule

// File: tb/tb_memory_cycle.sv
// Directed vector bench for memory_cycle: table-driven loads/stores plus
// hand-written reset sequences.
module tb_memory_cycle;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWriteM, MemWriteM;
  logic [1:0]  ResultSrcM;
  logic [2:0]  funct3M;
  logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
  logic [4:0]  RdM;
  logic        RegWriteW;
  logic [1:0]  ResultSrcW;
  logic [31:0] ReadDataW, ALUResultW, PCPlus4W;
  logic [4:0]  RdW;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  memory_cycle #(.DMEM_WORDS(1024)) dut (
    .clk        (clk),
    .rst        (rst),
    .RegWriteM  (RegWriteM),
    .MemWriteM  (MemWriteM),
    .ResultSrcM (ResultSrcM),
    .funct3M    (funct3M),
    .ALUResultM (ALUResultM),
    .WriteDataM (WriteDataM),
    .PCPlus4M   (PCPlus4M),
    .RdM        (RdM),
    .RegWriteW  (RegWriteW),
    .ResultSrcW (ResultSrcW),
    .ReadDataW  (ReadDataW),
    .ALUResultW (ALUResultW),
    .PCPlus4W   (PCPlus4W),
    .RdW        (RdW)
  );

  typedef struct {
    logic        rw;
    logic        mw;
    logic [1:0]  rs;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic        chk;
    logic [31:0] exp_rd;
    string       name;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rw, input logic mw, input logic [1:0] rs,
                              input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [4:0] rd,
                              input logic chk, input logic [31:0] exp_rd,
                              input string name);
    vec_t v;
    v.rw = rw; v.mw = mw; v.rs = rs; v.f3 = f3; v.addr = addr;
    v.wdata = wdata; v.rd = rd; v.chk = chk; v.exp_rd = exp_rd; v.name = name;
    return v;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_pass(input string name, input logic rw, input logic [1:0] rs,
                            input logic [31:0] alu, input logic [31:0] pc, input logic [4:0] rd);
    logic [71:0] act, exp;
    act = {RegWriteW, ResultSrcW, ALUResultW, PCPlus4W, RdW};
    exp = {rw, rs, alu, pc, rd};
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s passthru: got rw=%0b rs=%0d alu=0x%08h pc=0x%08h rd=%0d expected rw=%0b rs=%0d alu=0x%08h pc=0x%08h rd=%0d",
               name, RegWriteW, ResultSrcW, ALUResultW, PCPlus4W, RdW, rw, rs, alu, pc, rd);
    end
  endtask

  task automatic check_all_zero(input string name);
    logic [103:0] act;
    act = {RegWriteW, ResultSrcW, ReadDataW, ALUResultW, PCPlus4W, RdW};
    checks++;
    if (act !== '0) begin
      failures++;
      $display("FAIL %s: W outputs not zero, got 0x%026h expected 0", name, act);
    end
  endtask

  task automatic drive(input logic rw, input logic mw, input logic [1:0] rs, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] pc, input logic [4:0] rd);
    RegWriteM = rw; MemWriteM = mw; ResultSrcM = rs; funct3M = f3;
    ALUResultM = addr; WriteDataM = wdata; PCPlus4M = pc; RdM = rd;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 2'b00, 3'b010, 32'h0, 32'h0, 32'h0, 5'd0);
    #1;
    check_all_zero("reset_initial");
    @(posedge clk); #1;
    check_all_zero("reset_held");
    rst = 1'b0;

    //                 rw  mw  rs     f3      addr          wdata         rd  chk  exp
    vecs.push_back(mk(0, 1, 2'b00, 3'b010, 32'h0000_0010, 32'hDEADBEEF, 0,  0, 0,             "sw_10"));
    vecs.push_back(mk(1, 0, 2'b01, 3'b010, 32'h0000_0010, 32'h0,        5,  1, 32'hDEADBEEF,  "lw_10"));
    vecs.push_back(mk(0, 1, 2'b00, 3'b010, 32'h0000_0010, 32'h11223344, 0,  0, 0,             "sw_10b"));
    vecs.push_back(mk(0, 1, 2'b00, 3'b000, 32'h0000_0013, 32'h12345680, 0,  0, 0,             "sb_13"));
    vecs.push_back(mk(1, 0, 2'b01, 3'b010, 32'h0000_0010, 32'h0,        6,  1, 32'h80223344,  "lw_after_sb"));
    vecs.push_back(mk(1, 0, 2'b01, 3'b000, 32'h0000_0013, 32'h0,        7,  1, 32'hFFFFFF80,  "lb_13"));
    vecs.push_back(mk(1, 0, 2'b01, 3'b100, 32'h0000_0013, 32'h0,        8,  1, 32'h00000080,  "lbu_13"));
    vecs.push_back(mk(1, 0, 2'b01, 3'b000, 32'h0000_0011, 32'h0,        9,  1, 32'h00000033,  "lb_11"));
    vecs.push_back(mk(0, 1, 2'b00, 3'b010, 32'h0000_0020, 32'hAAAA5555, 0,  0, 0,             "sw_20"));
    vecs.push_back(mk(0, 1, 2'b00, 3'b001, 32'h0000_0022, 32'hCAFE8001, 0,  0, 0,             "sh_22"));
    vecs.push_back(mk(1, 0, 2'b01, 3'b010, 32'h0000_0020, 32'h0,        10, 1, 32'h80015555,  "lw_after_sh"));
    vecs.push_back(mk(1, 0, 2'b01, 3'b001, 32'h0000_0022, 32'h0,        11, 1, 32'hFFFF8001,  "lh_22"));
    vecs.push_back(mk(1, 0, 2'b01, 3'b101, 32'h0000_0022, 32'h0,        12, 1, 32'h00008001,  "lhu_22"));
    vecs.push_back(mk(1, 0, 2'b01, 3'b001, 32'h0000_0023, 32'h0,        13, 1, 32'hFFFF8001,  "lh_23_mis"));
    vecs.push_back(mk(1, 0, 2'b01, 3'b001, 32'h0000_0020, 32'h0,        14, 1, 32'h00005555,  "lh_20"));
    vecs.push_back(mk(1, 0, 2'b01, 3'b101, 32'h0000_0021, 32'h0,        15, 1, 32'h00005555,  "lhu_21_mis"));
    vecs.push_back(mk(1, 0, 2'b01, 3'b010, 32'h0000_0023, 32'h0,        16, 1, 32'h80015555,  "lw_23_mis"));
    vecs.push_back(mk(0, 1, 2'b00, 3'b010, 32'h0000_0040, 32'h00000001, 0,  0, 0,             "sw_40_old"));
    vecs.push_back(mk(0, 1, 2'b01, 3'b010, 32'h0000_0040, 32'h00000002, 0,  1, 32'h00000001,  "rw_conflict_40"));
    vecs.push_back(mk(1, 0, 2'b01, 3'b010, 32'h0000_0040, 32'h0,        17, 1, 32'h00000002,  "lw_40_next"));
    vecs.push_back(mk(0, 1, 2'b00, 3'b010, 32'h0000_1000, 32'hCAFEF00D, 0,  0, 0,             "sw_1000_wrap"));
    vecs.push_back(mk(1, 0, 2'b01, 3'b010, 32'h0000_0000, 32'h0,        18, 1, 32'hCAFEF00D,  "lw_0_wrap"));
    vecs.push_back(mk(0, 1, 2'b00, 3'b010, 32'h0000_0050, 32'h00000000, 0,  0, 0,             "sw_50_clr"));
    vecs.push_back(mk(0, 1, 2'b00, 3'b000, 32'h0000_0051, 32'hFFFFFFAB, 0,  0, 0,             "sb_51"));
    vecs.push_back(mk(0, 1, 2'b00, 3'b001, 32'h0000_0052, 32'h99991234, 0,  0, 0,             "sh_52"));
    vecs.push_back(mk(1, 0, 2'b01, 3'b010, 32'h0000_0050, 32'h0,        19, 1, 32'h1234AB00,  "lw_50_merge"));
    vecs.push_back(mk(1, 0, 2'b01, 3'b110, 32'h0000_0050, 32'h0,        20, 1, 32'h1234AB00,  "ld_f3_110_word"));
    vecs.push_back(mk(0, 0, 2'b00, 3'b010, 32'h0000_0050, 32'h55555555, 0,  0, 0,             "bubble_no_store"));
    vecs.push_back(mk(1, 0, 2'b01, 3'b010, 32'h0000_0050, 32'h0,        21, 1, 32'h1234AB00,  "lw_after_bubble"));
    vecs.push_back(mk(1, 0, 2'b00, 3'b010, 32'h0000_0055, 32'h0,        0,  0, 0,             "x0_passthru"));
    vecs.push_back(mk(1, 0, 2'b10, 3'b010, 32'hFFFF_FFFC, 32'h0,        31, 0, 0,             "pc4_passthru"));

    foreach (vecs[i]) begin
      logic [31:0] pc;
      pc = 32'h0000_1000 + 32'(i) * 4;
      drive(vecs[i].rw, vecs[i].mw, vecs[i].rs, vecs[i].f3, vecs[i].addr, vecs[i].wdata, pc, vecs[i].rd);
      @(posedge clk); #1;
      check_pass(vecs[i].name, vecs[i].rw, vecs[i].rs, vecs[i].addr, pc, vecs[i].rd);
      if (vecs[i].chk) check32(vecs[i].name, ReadDataW, vecs[i].exp_rd);
    end

    // Asynchronous reset mid-cycle with non-zero W outputs.
    drive(1'b1, 1'b0, 2'b01, 3'b010, 32'h0000_0010, 32'h0, 32'h0000_2000, 5'd3);
    @(posedge clk); #1;
    check32("pre_reset_nonzero", ReadDataW, 32'h11223344 & 32'h80223344 | 32'h80223344);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("reset_async_immediate");

    // Store presented at an edge while reset is high still lands.
    drive(1'b1, 1'b1, 2'b00, 3'b010, 32'h0000_0060, 32'h00000077, 32'h0000_3000, 5'd4);
    @(posedge clk); #1;
    check_all_zero("reset_blocks_register");
    rst = 1'b0;
    drive(1'b1, 1'b0, 2'b01, 3'b010, 32'h0000_0060, 32'h0, 32'h0000_3004, 5'd9);
    #1;
    check_all_zero("reset_release_no_edge");
    @(posedge clk); #1;
    check_pass("first_after_reset", 1'b1, 2'b01, 32'h0000_0060, 32'h0000_3004, 5'd9);
    check32("store_during_reset", ReadDataW, 32'h00000077);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
